rr_logging_packer: RTL and testbench
====================================

Name: rr_logging_packer

Overview:
- Sits directly downstream of the logging-bus grouping tree and consumes the fully grouped flat logging bus: per-channel logb/loge valid bits plus the concatenated logb data.
- Buffers each logging transaction in a FIFO.
- Serializes each transaction into fixed-width beats (one header beat, then data beats) on a valid/ready stream toward the log writer.
- Drives logb_almful back into the grouping tree for backpressure.

Parameters:
- CHANNEL_CNT, 4, number of logged channels (logb and loge bitmap width).
- DATA_WIDTH, 640, total grouped logb_data width (sum of channel widths).
- OUT_WIDTH, 512, output beat width; must be >= 2*CHANNEL_CNT.
- FIFO_DEPTH, 16, transaction entries; power of two, >= 4.
- ALMFUL_THRESH, 4, free-entry count at or below which almful asserts.

Ports:
- clk  in  1  single clock.
- sync_rst_n  in  1  synchronous active-low reset.
- in_logb_valid  in  CHANNEL_CNT  per-channel logb valid.
- in_logb_data  in  DATA_WIDTH  grouped logb data, channel 0 in LSBs.
- in_loge_valid  in  CHANNEL_CNT  per-channel loge valid.
- in_logb_almful  out  1  backpressure to the grouping tree.
- out_valid  out  1  beat valid.
- out_data  out  OUT_WIDTH  beat payload.
- out_last  out  1  final beat of a transaction.
- out_ready  in  1  downstream accept.
- overflow  out  1  sticky: a transaction was dropped.
- pkt_cnt  out  32  transactions fully emitted.

Behaviour:
- Reset (sync_rst_n low at a clk edge): FIFO emptied, FSM to IDLE. out_valid, out_last, overflow, pkt_cnt = 0; out_data = 0; in_logb_almful = 0. Reset mid-transaction discards partial output; no beat completes after reset.
- Write:
  - Transaction present when |in_logb_valid or |in_loge_valid.
  - Written as {loge_valid, logb_valid, logb_data} if not full.
  - If full, the transaction is dropped and overflow is set (sticky until reset).
- in_logb_almful: registered, = (FIFO_DEPTH - count) <= ALMFUL_THRESH, evaluated on next-state count.
- Beats per transaction:
  - NB = ceil(DATA_WIDTH/OUT_WIDTH) data beats, sent only if logb_valid != 0.
  - If logb_valid == 0: header only, with out_last = 1 on the header.
- Header beat layout: [CHANNEL_CNT-1:0] = logb_valid; [2*CHANNEL_CNT-1:CHANNEL_CNT] = loge_valid; all other bits 0.
- Data beat k (0-based) = logb_data[k*OUT_WIDTH +: OUT_WIDTH]. The last beat is zero-padded above DATA_WIDTH.
- FSM:
  - IDLE: if FIFO not empty, load header into the output register and go to HDR. out_valid rises the cycle after IDLE sees non-empty.
  - HDR: hold header until out_ready.
    - On handshake with logb_valid == 0: pop, increment pkt_cnt, go to IDLE.
    - On handshake otherwise: load data beat 0, go to DATA.
  - DATA: beat index counter 0..NB-1; hold beat until out_ready.
    - On handshake of beat NB-1 (out_last = 1): pop, increment pkt_cnt, go to IDLE.
    - Otherwise: advance index and load the next beat.
- Latency: input at edge t is written at t, so FIFO is non-empty after t. IDLE loads at t+1; out_valid is high after edge t+1 (2 cycles input-to-header).
- No back-to-back bubble removal required: IDLE costs 1 cycle between transactions.
- Output stability: while out_valid && !out_ready, out_data and out_last are held constant.
- Simultaneous write and pop in the same cycle: count unchanged; a write to a full FIFO coincident with a pop is accepted.
- pkt_cnt wraps modulo 2^32.
- Assertion: no input transaction presented while in_logb_almful has been high for >= ALMFUL_THRESH cycles. Violation is reported in simulation only.

Test Plan:
- Single transaction, logb_valid=4'b0011, loge_valid=0, data=640'hA..., out_ready=1 -> header 0x3 at t+2, then data beats 0 and 1 (beat 1 low 128 bits = data[639:512], rest zero), out_last on beat 1, pkt_cnt=1.
- loge-only transaction, loge_valid=4'b1000 -> single header beat = 0x80 with out_last=1, no data beats, pkt_cnt=1.
- Backpressure: out_ready low for 5 cycles mid-DATA -> out_data/out_last stable throughout, correct beat completes on the first ready cycle.
- Fill: out_ready=0, 16 consecutive transactions -> in_logb_almful high once free <= 4 (after the 12th write). A 17th transaction sets overflow=1 and is dropped. Releasing ready emits exactly 16 transactions, pkt_cnt=16.
- Simultaneous write/pop while full: pop on the same cycle as a write -> write accepted, overflow stays 0.
- Reset asserted mid-DATA beat -> next cycle out_valid=0, FIFO empty, pkt_cnt=0. A subsequent transaction emits normally.

Source files
------------

// File: rtl/rr_logging_packer.sv
// rtl/rr_logging_packer.sv - buffers grouped logging transactions and serializes them into header + data beats
//
// Ports:
//   clk, sync_rst_n    single clock, synchronous active-low reset
//   in_logb_valid      per-channel logb valid bitmap
//   in_logb_data       grouped logb data, channel 0 in the LSBs
//   in_loge_valid      per-channel loge valid bitmap
//   in_logb_almful     registered backpressure toward the grouping tree
//   out_valid/out_data/out_last/out_ready   beat stream toward the log writer
//   overflow           sticky, a transaction was dropped on a full FIFO
//   pkt_cnt            transactions fully emitted (wraps)
module rr_logging_packer #(
  parameter int CHANNEL_CNT   = 4,
  parameter int DATA_WIDTH    = 640,
  parameter int OUT_WIDTH     = 512,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFUL_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   sync_rst_n,
  input  logic [CHANNEL_CNT-1:0] in_logb_valid,
  input  logic [DATA_WIDTH-1:0]  in_logb_data,
  input  logic [CHANNEL_CNT-1:0] in_loge_valid,
  output logic                   in_logb_almful,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [31:0]            pkt_cnt
);

  localparam int NB = (DATA_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int EW = DATA_WIDTH + 2 * CHANNEL_CNT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic                   almful_q, almful_d;

  logic                   present, full, empty, wr_en, pop;
  logic [EW-1:0]          head;
  logic [CHANNEL_CNT-1:0] head_logb, head_loge;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [NB*OUT_WIDTH-1:0] padded;
  logic [OUT_WIDTH-1:0]   beats [NB];
  logic [OUT_WIDTH-1:0]   hdr;

  assign present = (|in_logb_valid) || (|in_loge_valid);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_en   = present && (!full || pop);

  assign head      = mem_q[rd_ptr_q];
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_logb = head[DATA_WIDTH +: CHANNEL_CNT];
  assign head_loge = head[DATA_WIDTH+CHANNEL_CNT +: CHANNEL_CNT];

  always_comb begin
    padded = '0;
    padded[DATA_WIDTH-1:0] = head_data;
    for (int k = 0; k < NB; k++) begin
      beats[k] = padded[k*OUT_WIDTH +: OUT_WIDTH];
    end
    hdr = '0;
    hdr[2*CHANNEL_CNT-1:0] = {head_loge, head_logb};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          out_data_d  = hdr;
          out_last_d  = (head_logb == '0);
          out_valid_d = 1'b1;
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_ready) begin
          if (head_logb == '0) begin
            pop         = 1'b1;
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            idx_d      = '0;
            out_data_d = beats[0];
            out_last_d = (NB == 1);
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (out_ready) begin
          if (idx_q == IW'(NB - 1)) begin
            pop         = 1'b1;
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            out_data_d = beats[idx_d];
            out_last_d = (idx_d == IW'(NB - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_d    = count_q + CW'(wr_en) - CW'(pop);
  assign overflow_d = overflow_q | (present & ~wr_en);
  // Evaluated on the next-state count so the flag tracks the write that fills it.
  assign almful_d   = ((CW'(FIFO_DEPTH) - count_d) <= CW'(ALMFUL_THRESH));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {in_loge_valid, in_logb_valid, in_logb_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      almful_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      pkt_cnt_q   <= pkt_cnt_d;
      almful_q    <= almful_d;
    end
  end

  assign in_logb_almful = almful_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign overflow       = overflow_q;
  assign pkt_cnt        = pkt_cnt_q;

`ifndef SYNTHESIS
  // Counts edges for which almful has already been high; the grouping tree
  // is allowed ALMFUL_THRESH cycles of reaction time before it must stop.
  logic [7:0] almful_cyc_q;
  always_ff @(posedge clk) begin
    if (!sync_rst_n || !almful_q) begin
      almful_cyc_q <= '0;
    end else if (almful_cyc_q != '1) begin
      almful_cyc_q <= almful_cyc_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (sync_rst_n && almful_q && present && (int'(almful_cyc_q) + 1 >= ALMFUL_THRESH)) begin
      $warning("rr_logging_packer: transaction presented after almful held %0d cycles",
               int'(almful_cyc_q) + 1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_logging_packer.sv
// tb/tb_rr_logging_packer.sv - directed table-driven bench for rr_logging_packer
module tb_rr_logging_packer;

  localparam int CH    = 4;
  localparam int DW    = 640;
  localparam int OW    = 512;
  localparam int DEPTH = 16;
  localparam int THR   = 4;

  logic          clk = 1'b0;
  logic          sync_rst_n;
  logic [CH-1:0] in_logb_valid;
  logic [DW-1:0] in_logb_data;
  logic [CH-1:0] in_loge_valid;
  logic          in_logb_almful;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          overflow;
  logic [31:0]   pkt_cnt;

  always #5 clk = ~clk;

  rr_logging_packer #(
    .CHANNEL_CNT(CH), .DATA_WIDTH(DW), .OUT_WIDTH(OW),
    .FIFO_DEPTH(DEPTH), .ALMFUL_THRESH(THR)
  ) dut (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_logb_valid(in_logb_valid), .in_logb_data(in_logb_data),
    .in_loge_valid(in_loge_valid), .in_logb_almful(in_logb_almful),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .overflow(overflow), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic [CH-1:0] logb;
    logic [CH-1:0] loge;
    logic [DW-1:0] data;
    logic [7:0]    hdr;
    int            nb;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_hdrs [$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [OW-1:0] data_beat(input logic [DW-1:0] d, input int k);
    logic [2*OW-1:0] p;
    p = '0;
    p[DW-1:0] = d;
    return p[k*OW +: OW];
  endfunction

  task automatic idle_inputs();
    in_logb_valid = '0;
    in_loge_valid = '0;
    in_logb_data  = '0;
  endtask

  task automatic drive(input logic [CH-1:0] logb, input logic [CH-1:0] loge, input logic [DW-1:0] d);
    in_logb_valid = logb;
    in_loge_valid = loge;
    in_logb_data  = d;
  endtask

  task automatic reset_dut();
    sync_rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    sync_rst_n = 1'b1;
  endtask

  // One transaction with out_ready held high; every beat and the latency are checked.
  task automatic run_txn(input vec_t v, input int exp_pkt, input string tag);
    out_ready = 1'b1;
    drive(v.logb, v.loge, v.data);
    @(negedge clk);
    idle_inputs();
    check({tag, "_lat1_valid"}, OW'(out_valid), OW'(0));
    @(negedge clk);
    for (int b = 0; b < v.nb; b++) begin
      check({tag, "_beat_valid"}, OW'(out_valid), OW'(1));
      check({tag, "_beat_data"}, out_data, (b == 0) ? OW'(v.hdr) : data_beat(v.data, b - 1));
      check({tag, "_beat_last"}, OW'(out_last), OW'(b == v.nb - 1));
      @(negedge clk);
    end
    check({tag, "_end_valid"}, OW'(out_valid), OW'(0));
    check({tag, "_pkt_cnt"}, OW'(pkt_cnt), OW'(exp_pkt));
  endtask

  // Emits with out_ready high and checks each transaction header in order.
  task automatic drain(input int n_exp);
    int n   = 0;
    int cyc = 0;
    bit first = 1'b1;
    out_ready = 1'b1;
    while (n < n_exp && cyc < 1000) begin
      if (out_valid) begin
        if (first) check("drain_hdr", out_data, OW'(exp_hdrs[n]));
        first = out_last;
        if (out_last) n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_count", OW'(n), OW'(n_exp));
  endtask

  initial begin
    logic [DW-1:0]  bp_data;
    logic [CH-1:0]  lb, le;

    vecs[0] = '{logb: 4'b0011, loge: 4'b0000, data: {160{4'hA}},                   hdr: 8'h03, nb: 3};
    vecs[1] = '{logb: 4'b0000, loge: 4'b1000, data: {20{32'h1357_9BDF}},           hdr: 8'h80, nb: 1};
    vecs[2] = '{logb: 4'b1111, loge: 4'b0101, data: {20{32'hDEAD_BEEF}},           hdr: 8'h5F, nb: 3};
    vecs[3] = '{logb: 4'b0100, loge: 4'b0010, data: {{5{128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978}}}, hdr: 8'h24, nb: 3};

    out_ready = 1'b0;
    reset_dut();
    sync_rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_last", OW'(out_last), OW'(0));
    check("rst_out_data", out_data, OW'(0));
    check("rst_overflow", OW'(overflow), OW'(0));
    check("rst_pkt_cnt", OW'(pkt_cnt), OW'(0));
    check("rst_almful", OW'(in_logb_almful), OW'(0));
    sync_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i], i + 1, $sformatf("vec%0d", i));
    end

    // Backpressure for 5 cycles while data beat 0 is on the bus.
    bp_data = {{4{32'hCAFE_F00D}}, {16{32'h0BAD_BEEF}}};
    out_ready = 1'b0;
    drive(4'b0001, 4'b0000, bp_data);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("bp_hdr", out_data, OW'(8'h01));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", OW'(out_valid), OW'(1));
      check("bp_hold_data", out_data, data_beat(bp_data, 0));
      check("bp_hold_last", OW'(out_last), OW'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_beat1_data", out_data, data_beat(bp_data, 1));
    check("bp_beat1_last", OW'(out_last), OW'(1));
    @(negedge clk);
    check("bp_end_valid", OW'(out_valid), OW'(0));
    check("bp_pkt_cnt", OW'(pkt_cnt), OW'(5));

    // Fill to 16 with the sink stalled, then overflow with a 17th.
    out_ready = 1'b0;
    reset_dut();
    exp_hdrs.delete();
    for (int i = 0; i < DEPTH; i++) begin
      lb = CH'((i % 15) + 1);
      le = CH'(i);
      exp_hdrs.push_back({le, lb});
      drive(lb, le, {20{32'(i) + 32'h5000_0000}});
      @(negedge clk);
      check($sformatf("fill_almful_%0d", i + 1), OW'(in_logb_almful), OW'(i + 1 >= 12));
    end
    drive(4'b0000, 4'b1111, '0);
    @(negedge clk);
    idle_inputs();
    check("fill_overflow", OW'(overflow), OW'(1));
    check("fill_almful_full", OW'(in_logb_almful), OW'(1));
    check("fill_pkt_before", OW'(pkt_cnt), OW'(0));
    drain(DEPTH);
    check("fill_pkt_cnt", OW'(pkt_cnt), OW'(16));
    check("fill_almful_clear", OW'(in_logb_almful), OW'(0));
    check("fill_end_valid", OW'(out_valid), OW'(0));

    // Write coincident with a pop while full is accepted.
    out_ready = 1'b0;
    reset_dut();
    exp_hdrs.delete();
    for (int i = 0; i < DEPTH; i++) begin
      le = CH'((i % 15) + 1);
      exp_hdrs.push_back({le, 4'b0000});
      drive(4'b0000, le, '0);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    check("wp_full_almful", OW'(in_logb_almful), OW'(1));
    out_ready = 1'b1;
    exp_hdrs.push_back({4'b1001, 4'b0000});
    drive(4'b0000, 4'b1001, '0);
    @(negedge clk);
    idle_inputs();
    check("wp_overflow", OW'(overflow), OW'(0));
    void'(exp_hdrs.pop_front());
    drain(DEPTH);
    check("wp_pkt_cnt", OW'(pkt_cnt), OW'(17));

    // Reset asserted while a data beat is stalled on the bus.
    out_ready = 1'b1;
    drive(4'b0010, 4'b0000, bp_data);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    check("mrst_pre_valid", OW'(out_valid), OW'(1));
    sync_rst_n = 1'b0;
    @(negedge clk);
    check("mrst_valid", OW'(out_valid), OW'(0));
    check("mrst_pkt_cnt", OW'(pkt_cnt), OW'(0));
    check("mrst_last", OW'(out_last), OW'(0));
    sync_rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mrst_empty_valid", OW'(out_valid), OW'(0));
    end
    run_txn(vecs[2], 1, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
